// File: rtl/btle_rx_pdu_buffer_pkg.sv
// rtl/btle_rx_pdu_buffer_pkg.sv - shared types and helpers for the BLE receive PDU buffer
package btle_rx_pdu_buffer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RECEIVE = 2'd1,
        ST_DROP    = 2'd2
    } rx_state_t;

    localparam int CRC_FLAG_W = 1;

    // Pointer width including the extra wrap bit.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/btle_rx_desc_fifo.sv
// rtl/btle_rx_desc_fifo.sv - synchronous FIFO of committed packet descriptors {len, crc_flag}
module btle_rx_desc_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_idx;
    logic [AW:0]      rd_idx;
    logic             do_push;
    logic             do_pop;

    assign full    = (wr_idx ^ rd_idx) == {1'b1, {AW{1'b0}}};
    assign empty   = wr_idx == rd_idx;
    assign count   = wr_idx - rd_idx;
    assign dout    = mem[rd_idx[AW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_idx <= '0;
            rd_idx <= '0;
        end else begin
            if (do_push)
                wr_idx <= wr_idx + 1'b1;
            if (do_pop)
                rd_idx <= rd_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_idx[AW-1:0]] <= din;
    end

endmodule

// File: rtl/btle_rx_pdu_buffer.sv
// rtl/btle_rx_pdu_buffer.sv - BLE receive packet buffer; commits CRC-good packets, FWFT read side
// Option macro BTLE_RX_PDU_BUFFER_KEEP_BAD_EN: commit CRC failures too, flagged via rd_pkt_crc_ok.
module btle_rx_pdu_buffer
    import btle_rx_pdu_buffer_pkg::*;
#(
    parameter int DEPTH         = 256,
    parameter int DESC_DEPTH    = 4,
    parameter int LEN_BIT_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          pkt_start,
    input  logic [7:0]                    octet,
    input  logic                          octet_valid,
    input  logic                          decode_end,
    input  logic                          crc_ok,
    output logic [7:0]                    rd_octet,
    output logic                          rd_valid,
    input  logic                          rd_ready,
    output logic                          rd_last,
    output logic [LEN_BIT_WIDTH-1:0]      rd_pkt_len,
    output logic                          rd_pkt_crc_ok,
    output logic [$clog2(DESC_DEPTH):0]   pkt_count,
    output logic [7:0]                    drop_count
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PTR_W  = ptr_width(DEPTH);
    localparam int CNT_W  = $clog2(DESC_DEPTH) + 1;
    localparam int DESC_W = LEN_BIT_WIDTH + CRC_FLAG_W;
    localparam logic [LEN_BIT_WIDTH-1:0] LEN_MAX = '1;

    logic [7:0]               mem [DEPTH];
    rx_state_t                state, state_nxt;
    logic [PTR_W-1:0]         wr_ptr, wr_ptr_nxt;
    logic [PTR_W-1:0]         wr_commit, wr_commit_nxt;
    logic [PTR_W-1:0]         rd_ptr;
    logic [PTR_W-1:0]         wr_ptr_cur;
    logic [LEN_BIT_WIDTH-1:0] len_cnt, len_nxt, len_cur;
    logic [LEN_BIT_WIDTH-1:0] rd_consumed;
    logic [LEN_BIT_WIDTH-1:0] head_len;
    logic [LEN_BIT_WIDTH-1:0] remaining;
    logic [7:0]               drop_cnt;
    logic                     ram_full;
    logic                     overflow;
    logic                     mem_we;
    logic                     drop_inc;
    logic                     crc_accept;
    logic                     crc_flag;
    logic                     head_crc;
    logic                     accept;
    logic                     desc_push;
    logic                     desc_pop;
    logic                     desc_full;
    logic                     desc_empty;
    logic [DESC_W-1:0]        desc_din;
    logic [DESC_W-1:0]        desc_dout;
    logic [CNT_W-1:0]         desc_count;

`ifdef BTLE_RX_PDU_BUFFER_KEEP_BAD_EN
    assign crc_accept = 1'b1;
    assign crc_flag   = crc_ok;
`else
    assign crc_accept = crc_ok;
    assign crc_flag   = 1'b1;
`endif

    assign ram_full = (wr_ptr ^ rd_ptr) == {1'b1, {ADDR_W{1'b0}}};

    always_comb begin
        state_nxt     = state;
        wr_ptr_nxt    = wr_ptr;
        wr_commit_nxt = wr_commit;
        len_nxt       = len_cnt;
        wr_ptr_cur    = wr_ptr;
        len_cur       = len_cnt;
        overflow      = 1'b0;
        mem_we        = 1'b0;
        drop_inc      = 1'b0;
        desc_push     = 1'b0;
        desc_din      = {len_cnt, crc_flag};

        case (state)
            ST_IDLE: begin
                if (pkt_start) begin
                    wr_ptr_nxt = wr_commit;
                    len_nxt    = '0;
                    state_nxt  = ST_RECEIVE;
                end
            end

            ST_RECEIVE: begin
                // The octet lands before any commit decision taken in the same cycle.
                if (octet_valid) begin
                    if (ram_full) begin
                        overflow = 1'b1;
                    end else begin
                        mem_we     = 1'b1;
                        wr_ptr_cur = wr_ptr + 1'b1;
                        len_cur    = (len_cnt == LEN_MAX) ? len_cnt : len_cnt + 1'b1;
                    end
                end
                wr_ptr_nxt = wr_ptr_cur;
                len_nxt    = len_cur;
                if (overflow)
                    state_nxt = ST_DROP;

                if (decode_end) begin
                    if (!overflow && crc_accept && (len_cur != '0) && !desc_full) begin
                        wr_commit_nxt = wr_ptr_cur;
                        desc_push     = 1'b1;
                        desc_din      = {len_cur, crc_flag};
                    end else begin
                        wr_ptr_nxt = wr_commit;
                        drop_inc   = 1'b1;
                    end
                    state_nxt = ST_IDLE;
                end else if (pkt_start) begin
                    drop_inc = 1'b1;
                end

                if (pkt_start) begin
                    wr_ptr_nxt = wr_commit_nxt;
                    len_nxt    = '0;
                    state_nxt  = ST_RECEIVE;
                end
            end

            ST_DROP: begin
                if (decode_end || pkt_start) begin
                    wr_ptr_nxt = wr_commit;
                    drop_inc   = 1'b1;
                    state_nxt  = ST_IDLE;
                end
                if (pkt_start) begin
                    len_nxt   = '0;
                    state_nxt = ST_RECEIVE;
                end
            end

            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            wr_ptr    <= '0;
            wr_commit <= '0;
            len_cnt   <= '0;
            drop_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            wr_ptr    <= wr_ptr_nxt;
            wr_commit <= wr_commit_nxt;
            len_cnt   <= len_nxt;
            if (drop_inc && drop_cnt != 8'hFF)
                drop_cnt <= drop_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[wr_ptr[ADDR_W-1:0]] <= octet;
    end

    btle_rx_desc_fifo #(
        .DEPTH (DESC_DEPTH),
        .WIDTH (DESC_W)
    ) u_desc_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (desc_push),
        .din   (desc_din),
        .pop   (desc_pop),
        .dout  (desc_dout),
        .full  (desc_full),
        .empty (desc_empty),
        .count (desc_count)
    );

    // Remaining octets of the head packet = head length minus octets already consumed.
    assign head_len      = desc_dout[DESC_W-1:CRC_FLAG_W];
    assign head_crc      = desc_dout[0];
    assign remaining     = head_len - rd_consumed;
    assign rd_valid      = !desc_empty;
    assign rd_last       = rd_valid && (remaining == LEN_BIT_WIDTH'(1));
    assign rd_octet      = rd_valid ? mem[rd_ptr[ADDR_W-1:0]] : 8'h00;
    assign rd_pkt_len    = rd_valid ? head_len : '0;
    assign rd_pkt_crc_ok = rd_valid && head_crc;
    assign pkt_count     = desc_count;
    assign drop_count    = drop_cnt;
    assign accept        = rd_valid && rd_ready;
    assign desc_pop      = accept && rd_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr      <= '0;
            rd_consumed <= '0;
        end else if (accept) begin
            rd_ptr      <= rd_ptr + 1'b1;
            rd_consumed <= rd_last ? '0 : rd_consumed + 1'b1;
        end
    end

endmodule

// File: doc/btle_rx_pdu_buffer.md
Name: btle_rx_pdu_buffer

Overview:
Packet buffer directly downstream of the BLE receive core. Captures the decoded octet stream (header plus payload) of each packet, delimited by the access-address hit and decode_end. On decode_end it commits the packet if the CRC passed and discards it otherwise. Committed packets are presented to the host/SoC side as a length-tagged, first-word-fall-through octet stream with a valid/ready handshake.

Parameters:
DEPTH, 256, octet storage depth; power of 2, minimum 128.
DESC_DEPTH, 4, descriptor FIFO depth (maximum committed packets held); power of 2.
LEN_BIT_WIDTH, 8, width of the packet length field in octets.

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
pkt_start  in  1  one-cycle pulse at access-address hit (hit_flag); opens a packet
octet  in  8  decoded octet, LSB = first bit on air
octet_valid  in  1  octet strobe
decode_end  in  1  one-cycle end-of-packet pulse
crc_ok  in  1  CRC result, qualified by decode_end
rd_octet  out  8  head octet of the oldest committed packet
rd_valid  out  1  rd_octet is valid
rd_ready  in  1  consumer accepts rd_octet when rd_valid && rd_ready
rd_last  out  1  rd_octet is the final octet of its packet
rd_pkt_len  out  LEN_BIT_WIDTH  length of the head packet; valid while rd_valid
rd_pkt_crc_ok  out  1  CRC status of the head packet (always 1 unless the option is enabled)
pkt_count  out  clog2(DESC_DEPTH)+1  number of committed, unread packets
drop_count  out  8  saturating count of dropped packets

Behaviour:
- Reset: all pointers 0; state IDLE; rd_valid, rd_last, rd_pkt_len, rd_pkt_crc_ok, pkt_count and drop_count all 0. rd_octet = 0 (memory contents undefined).
- Storage: octet RAM of DEPTH entries. Three pointers, each ADDR_W+1 bits (extra wrap bit): wr_ptr (speculative), wr_commit, rd_ptr.
  - Full when wr_ptr and rd_ptr differ only in the MSB.
  - Empty for read when rd_ptr == wr_commit.
- Descriptor FIFO: one entry per committed packet, holding {len, crc_flag}.
- FSM states: IDLE, RECEIVE, DROP.
  - IDLE: on pkt_start, set wr_ptr = wr_commit, clear len_cnt, go to RECEIVE. octet_valid and decode_end are ignored in IDLE.
  - RECEIVE, octet_valid with the RAM not full: write the octet at wr_ptr, increment wr_ptr and len_cnt.
  - RECEIVE, octet_valid with the RAM full: go to DROP (overflow).
  - RECEIVE, decode_end: commit when crc_ok && len_cnt != 0 && descriptor FIFO not full. Commit sets wr_commit <= wr_ptr, pushes {len_cnt, 1}, then goes to IDLE. Otherwise roll back (wr_ptr <= wr_commit), increment drop_count, go to IDLE.
  - DROP: ignore octets. On decode_end, roll back, increment drop_count, go to IDLE.
  - pkt_start in RECEIVE or DROP (new hit before end): roll back, increment drop_count, restart RECEIVE in the same cycle.
  - pkt_start and decode_end in the same cycle: decode_end is processed first, then the new packet opens.
  - octet_valid coincident with decode_end: the octet is written before the commit decision.
  - len_cnt saturates at 2^LEN_BIT_WIDTH-1.
- Read side (first-word-fall-through):
  - rd_octet = mem[rd_ptr] combinationally.
  - rd_valid = (pkt_count != 0).
  - rd_pkt_len and rd_pkt_crc_ok come from the descriptor FIFO head.
  - rd_last is asserted when remaining == 1; a per-packet remaining counter loads from the head length.
  - Accept: increment rd_ptr and decrement remaining. Accepting with rd_last pops the descriptor.
- pkt_count: incremented on commit, decremented on the final pop. A commit and a pop in the same cycle leave it unchanged.
- drop_count saturates at 255.
- Commit-to-rd_valid latency: 1 cycle (registered pkt_count).

Optional Feature:
BTLE_RX_PDU_BUFFER_KEEP_BAD_EN.
- Defined: packets with crc_ok == 0 are committed like good packets, with crc_flag = 0. rd_pkt_crc_ok reflects the flag. drop_count counts only overflow, descriptor-full, zero-length and aborted packets.
- Undefined: CRC failures are rolled back and counted in drop_count; rd_pkt_crc_ok is tied to 1.

Decomposition:
- Shared package btle_rx_pdu_buffer_pkg: state encoding localparams (IDLE/RECEIVE/DROP), descriptor field widths, pointer width function (clog2).
- One sub-module: btle_rx_desc_fifo, a synchronous FIFO of {len, crc_flag} with push/pop/full/empty/count. The octet RAM and the FSM stay in the top module.

Test Plan:
- Good packet: pkt_start; octets 0x40,0x03,0xA1,0xB2,0xC3; decode_end with crc_ok=1 -> next cycle rd_valid=1, rd_pkt_len=5, pkt_count=1; read with rd_ready=1 returns 0x40..0xC3, rd_last on 0xC3, then pkt_count=0.
- CRC fail: 4 octets then decode_end with crc_ok=0 -> rd_valid stays 0, drop_count=1, wr_ptr restored. With KEEP_BAD_EN: rd_pkt_len=4, rd_pkt_crc_ok=0.
- Overflow: DEPTH=128, no reads, commit packets until RAM space is exhausted -> the overflowing packet is dropped (drop_count+1), earlier packets read back intact, pointers wrap correctly after draining.
- Abort: pkt_start, 3 octets, then pkt_start again and a 2-octet good packet -> only the 2-octet packet is readable, drop_count=1.
- Descriptor full: DESC_DEPTH=4, five good packets with no reads -> pkt_count=4, drop_count=1; reading one packet then committing a sixth succeeds.
- Backpressure and reset: rd_ready toggling every cycle keeps data order intact; asserting rst mid-RECEIVE -> all outputs 0, and the next packet is received cleanly.
